fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-cycle next-PC/instruction-memory path with a registered fetch PC, a handshaked instruction-memory port and a DEPTH-entry prefetch FIFO. It sits between instruction memory and decode. It supplies {pc, instruction} pairs under valid/ready flow control, and accepts redirects (branch, jump, jr) that flush all speculative work.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 65 ++++++
 tb/tb_fetch_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between instruction memory, the fetch queue and decode
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4
);
  logic redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_ack;
  logic [31:0] mem_data;
  logic inst_valid;
  logic [31:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic inst_ready;
  logic [$clog2(DEPTH):0] occupancy;
  modport master (
    input redirect, redirect_addr, mem_ack, mem_data, inst_ready,
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc, occupancy
  );
  modport slave (
    output redirect, redirect_addr, mem_ack, mem_data, inst_ready,
    input mem_req, mem_addr, inst_valid, inst_data, inst_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: registered fetch PC, single-outstanding memory request and DEPTH-entry prefetch FIFO
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] fetch_pc, addr;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic req, discard, push, pop, space;
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count, count_next;
  always_comb begin
    push = req & bus.mem_ack & ~discard & ~bus.redirect;
    pop = (count != '0) & bus.inst_ready & ~bus.redirect;
    count_next = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
    space = count_next < CW'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      addr <= '0;
      req <= 1'b0;
      discard <= 1'b0;
      count <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      count <= count_next;
      rd <= bus.redirect ? '0 : rd + PW'(pop);
      wr <= bus.redirect ? '0 : wr + PW'(push);
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_addr & ~ADDR_W'(3);
        req <= req & ~bus.mem_ack;
        discard <= req & ~bus.mem_ack;
      end else if (!req) begin
        req <= space;
        discard <= 1'b0;
        if (space) addr <= fetch_pc;
      end else if (bus.mem_ack) begin
        // a drained response never restarts fetch on the same edge
        req <= ~discard & space;
        discard <= 1'b0;
        if (!discard) fetch_pc <= addr + ADDR_W'(4);
        if (!discard && space) addr <= addr + ADDR_W'(4);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wr] <= addr;
      data_q[wr] <= bus.mem_data;
    end
  assign bus.mem_req = req;
  assign bus.mem_addr = addr;
  assign bus.inst_valid = count != '0;
  assign bus.inst_data = data_q[rd];
  assign bus.inst_pc = pc_q[rd];
  assign bus.occupancy = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random stimulus against a queue-based model, plus directed wrap and async-reset steps
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  fetch_queue_if #(.ADDR_W(32), .DEPTH(4)) bus();
  fetch_queue_if #(.ADDR_W(8), .DEPTH(4)) bus8();
  fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  assign bus8.mem_data = {24'hABCDEF, bus8.mem_addr};
  logic [31:0] q_pc[$], q_d[$];
  logic m_req, m_drop;
  logic [31:0] m_addr, m_pc;
  int n_pass = 0, n_fail = 0, n_total = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q_pc.delete();
    q_d.delete();
    m_req = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
    m_pc = 32'h100;
  endtask
  task automatic model_step();
    bit done, drained;
    done = m_req && bus.mem_ack;
    drained = done && m_drop;
    if (bus.redirect) begin
      q_pc.delete();
      q_d.delete();
      m_pc = bus.redirect_addr & ~32'h3;
      m_drop = m_req && !bus.mem_ack;
      m_req = m_drop;
    end else begin
      if (bus.inst_ready && q_pc.size() > 0) begin
        void'(q_pc.pop_front());
        void'(q_d.pop_front());
      end
      if (done && !m_drop) begin
        q_pc.push_back(m_addr);
        q_d.push_back(bus.mem_data);
        m_pc = m_addr + 32'd4;
      end
      if (done) begin
        m_req = 1'b0;
        m_drop = 1'b0;
      end
      if (!m_req && !drained && q_pc.size() < 4) begin
        m_req = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask
  task automatic check_all();
    chk("mem_req", 32'(bus.mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", bus.mem_addr, m_addr);
    chk("inst_valid", 32'(bus.inst_valid), 32'(q_pc.size() != 0));
    chk("occupancy", 32'(bus.occupancy), q_pc.size());
    if (q_pc.size() != 0) begin
      chk("inst_pc", bus.inst_pc, q_pc[0]);
      chk("inst_data", bus.inst_data, q_d[0]);
    end
  endtask
  task automatic run(int n, int p_ack, int p_rdy, int p_redir);
    repeat (n) begin
      bus.mem_ack = $urandom_range(0, 99) < p_ack;
      bus.inst_ready = $urandom_range(0, 99) < p_rdy;
      bus.redirect = $urandom_range(0, 99) < p_redir;
      bus.redirect_addr = $urandom_range(0, 'h3ff);
      bus.mem_data = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    bus.inst_ready = 1'b0;
    bus8.redirect = 1'b0;
    bus8.redirect_addr = '0;
    bus8.mem_ack = 1'b1;
    bus8.inst_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all();
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    rst_n = 1'b1;
    run(6, 100, 100, 0);
    run(8, 100, 0, 0);
    run(1, 100, 100, 0);
    run(4, 100, 0, 0);
    run(5, 0, 50, 0);
    run(300, 70, 60, 8);
    run(200, 100, 100, 5);
    run(200, 40, 30, 10);
    run(5, 100, 100, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_req", 32'(bus.mem_req), 32'h0);
    chk("async_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("async_occupancy", 32'(bus.occupancy), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(20, 100, 100, 0);
    bus8.redirect = 1'b1;
    bus8.redirect_addr = 8'hFE;
    @(negedge clk);
    bus8.redirect = 1'b0;
    chk("wrap_flush_valid", 32'(bus8.inst_valid), 32'h0);
    chk("wrap_flush_req", 32'(bus8.mem_req), 32'h0);
    @(negedge clk);
    chk("wrap_req", 32'(bus8.mem_req), 32'h1);
    chk("wrap_addr_fc", 32'(bus8.mem_addr), 32'hFC);
    @(negedge clk);
    chk("wrap_valid", 32'(bus8.inst_valid), 32'h1);
    chk("wrap_pc_fc", 32'(bus8.inst_pc), 32'hFC);
    chk("wrap_data_fc", bus8.inst_data, 32'hABCDEFFC);
    chk("wrap_addr_00", 32'(bus8.mem_addr), 32'h00);
    @(negedge clk);
    chk("wrap_pc_00", 32'(bus8.inst_pc), 32'h00);
    chk("wrap_addr_04", 32'(bus8.mem_addr), 32'h04);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
